pulse_spacer: RTL and testbench
===============================

Name: pulse_spacer

Overview:
- Fast-domain (clka) stage that sits directly upstream of the 1-bit toggle-based fast-to-slow pulse synchroniser.
- Accepts bursts of single-cycle event pulses, including back-to-back pulses, and queues them in a saturating pending counter.
- Re-emits the pulses one at a time, guaranteed at least GAP clka cycles apart, so that every toggle survives the 3-flop clkb sampling.
- Reports backlog, activity, and lost events (sticky overflow).

Parameters:
- CNT_W, default 4: pending-counter width. Maximum backlog PMAX = 2^CNT_W - 1.
- GAP, default 8: minimum spacing in clka cycles between pulse_out assertions. Must be >= 2. 8 covers 300 MHz to 100 MHz with margin.

Ports:
- clka  input  1  source (fast) clock; all logic on its rising edge.
- src_rst_n  input  1  asynchronous active-low reset (0 = reset).
- pulse_in  input  1  event pulse; each high cycle is one event.
- clr  input  1  synchronous clear of backlog and overflow.
- pulse_out  output  1  spaced single-cycle event pulse; drives the synchroniser's Signal_a.
- pending  output  CNT_W  events accepted but not yet emitted.
- busy  output  1  high while pending != 0 or the gap timer is running.
- overflow  output  1  sticky; at least one event was dropped.

Behaviour:
- Reset (src_rst_n = 0, asynchronous):
  - pulse_out = 0, pending = 0, busy = 0, overflow = 0, gap timer = 0.
  - Takes effect immediately, including mid-burst; the backlog is discarded.
- Gap timer: internal down-counter, width clog2(GAP).
- Emission condition, evaluated per rising edge from registered values: emit = (pending != 0) && (gap == 0) && !clr.
- pulse_out:
  - Registered: pulse_out <= emit.
  - High for exactly one cycle per emission.
- Gap timer updates:
  - On emit: gap <= GAP-1.
  - Otherwise, if gap != 0: gap <= gap-1.
  - Consecutive pulse_out assertions are therefore exactly GAP cycles apart when backlog exists, and never closer.
- Latency: pulse_in sampled at edge k with an idle block gives pending = 1 after edge k, then pulse_out high and pending = 0 after edge k+1.
- Pending counter, one update per edge:
  - clr: pending <= 0, overflow <= 0. pulse_in on that edge is discarded without setting overflow. No emission on that edge. The gap timer keeps counting, so spacing is still guaranteed after clr.
  - pulse_in && emit: pending unchanged (simultaneous in/out).
  - pulse_in && !emit && pending < PMAX: pending + 1.
  - pulse_in && !emit && pending == PMAX: event dropped, overflow <= 1, pending stays PMAX.
  - emit only: pending - 1.
- overflow is cleared only by clr or reset.
- busy: combinational, (pending != 0) || (gap != 0). Drops only after the last gap window expires.
- State view:
  - IDLE: pending = 0, gap = 0.
  - EMIT: the edge where emit = 1.
  - HOLD: gap != 0; from here, go to EMIT when gap reaches 0 with pending != 0, otherwise IDLE.
- No combinational path from pulse_in to pulse_out.
- No wrap-around: pending saturates.

Test Plan:
- Reset: hold src_rst_n = 0 with pulse_in toggling -> pulse_out, pending, busy, overflow all 0. Release -> all remain 0 until the first pulse_in.
- Single pulse: one pulse_in at edge 0 -> pending = 1 after edge 0, pulse_out high for one cycle after edge 1, pending = 0, busy = 1 through edge 8 then 0 (GAP = 8).
- Burst of 5 back-to-back pulse_in at edges 0-4 -> pending peaks at 4 after edge 4. Five pulse_out at edges 1, 9, 17, 25, 33, each exactly 8 cycles apart. overflow = 0.
- Overflow (CNT_W = 4, GAP = 8): 20 back-to-back pulse_in -> pending saturates at 15, events at edges 18 and 19 dropped, overflow = 1. Exactly 18 pulse_out total. Then clr -> overflow = 0, pending = 0.
- clr and reset mid-operation:
  - clr asserted with pending = 6 -> pending = 0, no further pulse_out, busy falls when gap reaches 0.
  - Separately, src_rst_n pulsed low with pending = 6 -> outputs 0 asynchronously, no pulse_out after release.
- End-to-end with the downstream synchroniser: clka 300 MHz, clkb 100 MHz, GAP = 8, 10 back-to-back pulse_in -> exactly 10 Signal_b pulses in the clkb domain, none merged.

Source files
------------

// File: rtl/pulse_spacer.sv
// pulse_spacer
//
// Fast-domain (clka) front end for a 1-bit toggle-based fast-to-slow pulse
// synchroniser. Single-cycle event pulses, including back-to-back bursts,
// are counted into a saturating backlog. They are re-emitted one at a time,
// at least GAP clka cycles apart, so that every toggle survives the slow
// side's three-flop sampling.
//
// Parameters
//   CNT_W : backlog counter width; maximum backlog is 2**CNT_W - 1.
//   GAP   : minimum clka cycles between pulse_out assertions (must be >= 2).
//
// Ports
//   clka      : source (fast) clock; all logic runs on its rising edge.
//   src_rst_n : asynchronous active-low reset; discards any backlog.
//   pulse_in  : event input; each high cycle is one event.
//   clr       : synchronous clear of the backlog and the overflow flag.
//   pulse_out : registered, spaced single-cycle pulse (drives Signal_a).
//   pending   : events accepted but not yet emitted.
//   busy      : backlog non-empty or spacing window still running.
//   overflow  : sticky; at least one event was dropped at full backlog.

module pulse_spacer #(
  parameter int CNT_W = 4,
  parameter int GAP   = 8
) (
  input  logic             clka,
  input  logic             src_rst_n,
  input  logic             pulse_in,
  input  logic             clr,
  output logic             pulse_out,
  output logic [CNT_W-1:0] pending,
  output logic             busy,
  output logic             overflow
);

  // The gap timer only ever holds 0 .. GAP-1.
  localparam int               GAP_W      = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CNT_W-1:0] PMAX       = {CNT_W{1'b1}};
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(GAP - 1);

  logic [CNT_W-1:0] pending_q, pending_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             overflow_q, overflow_d;
  logic             pulse_out_q;
  logic             emit;

  // Emission is decided purely from registered state plus clr, so there is
  // no combinational path from pulse_in to pulse_out.
  always_comb begin
    emit = (pending_q != '0) && (gap_q == '0) && !clr;
  end

  // Backlog update. A simultaneous arrival and emission leaves the count
  // unchanged, which is why a full backlog can still accept an event on an
  // emitting edge. An event arriving while clr is high is discarded silently.
  always_comb begin
    pending_d  = pending_q;
    overflow_d = overflow_q;
    if (clr) begin
      pending_d  = '0;
      overflow_d = 1'b0;
    end else if (pulse_in && emit) begin
      pending_d = pending_q;
    end else if (pulse_in) begin
      if (pending_q == PMAX) begin
        overflow_d = 1'b1;
      end else begin
        pending_d = pending_q + CNT_W'(1);
      end
    end else if (emit) begin
      pending_d = pending_q - CNT_W'(1);
    end
  end

  // The gap timer keeps running through clr, so the spacing guarantee
  // towards the synchroniser still holds right after a clear.
  always_comb begin
    gap_d = gap_q;
    if (emit) begin
      gap_d = GAP_RELOAD;
    end else if (gap_q != '0) begin
      gap_d = gap_q - GAP_W'(1);
    end
  end

  always_ff @(posedge clka or negedge src_rst_n) begin
    if (!src_rst_n) begin
      pending_q   <= '0;
      gap_q       <= '0;
      overflow_q  <= 1'b0;
      pulse_out_q <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      gap_q       <= gap_d;
      overflow_q  <= overflow_d;
      pulse_out_q <= emit;
    end
  end

  assign pulse_out = pulse_out_q;
  assign pending   = pending_q;
  assign overflow  = overflow_q;
  assign busy      = (pending_q != '0) || (gap_q != '0);

endmodule

// File: tb/tb_pulse_spacer.sv
module tb_pulse_spacer;

  localparam int CNT_W = 4;
  localparam int GAP   = 8;
  localparam int PMAX  = (1 << CNT_W) - 1;

  // clka : clkb = 3 : 1, mirroring 300 MHz vs 100 MHz.
  logic clka = 1'b0;
  logic clkb = 1'b0;
  logic src_rst_n;
  logic pulse_in;
  logic clr;
  logic pulse_out;
  logic [CNT_W-1:0] pending;
  logic busy;
  logic overflow;

  always #5  clka = ~clka;
  always #15 clkb = ~clkb;

  pulse_spacer #(.CNT_W(CNT_W), .GAP(GAP)) dut (
    .clka      (clka),
    .src_rst_n (src_rst_n),
    .pulse_in  (pulse_in),
    .clr       (clr),
    .pulse_out (pulse_out),
    .pending   (pending),
    .busy      (busy),
    .overflow  (overflow)
  );

  // Downstream toggle synchroniser (behavioural) for the end-to-end check.
  logic       tog_a  = 1'b0;
  logic [2:0] sync_b = 3'b000;
  int         sigb_cnt = 0;

  always @(posedge clka) if (pulse_out === 1'b1) tog_a <= ~tog_a;
  always @(posedge clkb) sync_b <= {sync_b[1:0], tog_a};
  always @(posedge clkb) if (sync_b[2] ^ sync_b[1]) sigb_cnt <= sigb_cnt + 1;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (time %0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: event count plus the edge index of the last emission.
  // An emission at edge t is allowed once t - last >= GAP.
  int m_pend;
  int m_t;
  int m_last;
  bit m_ovf;
  bit m_emit;

  function automatic void model_reset();
    m_pend = 0;
    m_ovf  = 1'b0;
    m_emit = 1'b0;
    m_t    = 0;
    m_last = -1000;
  endfunction

  function automatic void model_edge(input bit pin, input bit c);
    m_emit = (m_pend > 0) && (m_t - m_last >= GAP) && !c;
    if (m_emit) m_last = m_t;
    if (c) begin
      m_pend = 0;
      m_ovf  = 1'b0;
    end else if (pin && !m_emit && m_pend == PMAX) begin
      m_ovf = 1'b1;
    end else begin
      m_pend = m_pend + (pin ? 1 : 0) - (m_emit ? 1 : 0);
    end
    m_t++;
  endfunction

  task automatic chk_model(input string tag);
    chk({tag, ".pulse_out"}, pulse_out, m_emit);
    chk({tag, ".pending"},   pending,   m_pend);
    chk({tag, ".busy"},      busy,      (m_pend > 0) || (m_t - m_last < GAP));
    chk({tag, ".overflow"},  overflow,  m_ovf);
  endtask

  int pulse_cnt;
  int edge_idx;
  int peak;
  int pulse_edges[$];

  task automatic start_seq();
    pulse_cnt = 0;
    edge_idx  = 0;
    peak      = 0;
    pulse_edges.delete();
  endtask

  // One clka edge: drive inputs, clock, advance the model, sample at +1.
  task automatic step(input bit pin, input bit c);
    pulse_in = pin;
    clr      = c;
    @(posedge clka);
    #1;
    model_edge(pin, c);
    if (pulse_out === 1'b1) begin
      pulse_cnt++;
      pulse_edges.push_back(edge_idx);
    end
    if (int'(pending) > peak) peak = int'(pending);
    edge_idx++;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 400 && busy !== 1'b0; i++) begin
      step(1'b0, 1'b0);
      chk_model(tag);
    end
    chk({tag, ".drained"}, busy, 1'b0);
  endtask

  typedef struct {
    bit pin;
    bit c;
    bit e_pulse;
    int e_pend;
    bit e_busy;
    bit e_ovf;
  } vec_t;

  vec_t tbl[13];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int base;
    int dens;

    // Single pulse then clr corner cases, starting from idle after reset.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0};
    for (int i = 2; i <= 7; i++) tbl[i] = '{1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 1, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0};

    // Reset held with pulse_in toggling.
    src_rst_n = 1'b0;
    pulse_in  = 1'b0;
    clr       = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      step(i[0] == 1'b0, 1'b0);
      model_reset();
      chk("rst_hold.pulse_out", pulse_out, 1'b0);
      chk("rst_hold.pending",   pending,   0);
      chk("rst_hold.busy",      busy,      1'b0);
      chk("rst_hold.overflow",  overflow,  1'b0);
    end
    src_rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0);
      chk_model("rst_release");
    end

    // Table-driven vectors.
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].pin, tbl[i].c);
      chk($sformatf("tbl%0d.pulse_out", i), pulse_out, tbl[i].e_pulse);
      chk($sformatf("tbl%0d.pending", i),   pending,   tbl[i].e_pend);
      chk($sformatf("tbl%0d.busy", i),      busy,      tbl[i].e_busy);
      chk($sformatf("tbl%0d.overflow", i),  overflow,  tbl[i].e_ovf);
    end
    drain("tbl_drain");

    // Burst of five back-to-back events.
    start_seq();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0);
      chk_model("burst5");
    end
    drain("burst5");
    chk("burst5.count", pulse_cnt, 5);
    chk("burst5.peak",  peak,      4);
    chk("burst5.overflow", overflow, 1'b0);
    for (int i = 0; i < pulse_edges.size(); i++)
      chk($sformatf("burst5.edge%0d", i), pulse_edges[i], 1 + GAP * i);

    // Overflow: 20 back-to-back events into a 15-deep backlog.
    start_seq();
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0);
      chk_model("ovf20");
    end
    drain("ovf20");
    chk("ovf20.count",    pulse_cnt, 18);
    chk("ovf20.peak",     peak,      PMAX);
    chk("ovf20.overflow", overflow,  1'b1);
    step(1'b0, 1'b1);
    chk("ovf20.clr_overflow", overflow, 1'b0);
    chk("ovf20.clr_pending",  pending,  0);

    // clr with a backlog of six.
    start_seq();
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0);
    chk("clrmid.pending_before", pending, 6);
    step(1'b0, 1'b1);
    chk_model("clrmid.clr");
    chk("clrmid.pending_after", pending, 0);
    pulse_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0);
      chk_model("clrmid.idle");
    end
    chk("clrmid.no_pulses", pulse_cnt, 0);
    chk("clrmid.busy_low",  busy,      1'b0);

    // Asynchronous reset with a backlog of six, asserted between edges.
    start_seq();
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0);
    pulse_in = 1'b0;
    chk("arst.pending_before", pending, 6);
    #2;
    src_rst_n = 1'b0;
    #1;
    chk("arst.pulse_out", pulse_out, 1'b0);
    chk("arst.pending",   pending,   0);
    chk("arst.busy",      busy,      1'b0);
    chk("arst.overflow",  overflow,  1'b0);
    @(posedge clka);
    #1;
    src_rst_n = 1'b1;
    model_reset();
    pulse_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0);
      chk_model("arst.after");
    end
    chk("arst.no_pulses", pulse_cnt, 0);

    // Randomised traffic against the model.
    dens = 10;
    for (int i = 0; i < 1600; i++) begin
      if (i % 200 == 0) dens = $urandom_range(5, 98);
      step($urandom_range(0, 99) < dens, $urandom_range(0, 59) == 0);
      chk_model("rand");
    end
    drain("rand_drain");
    step(1'b0, 1'b1);
    chk_model("rand_clr");

    // End to end through the toggle synchroniser: ten back-to-back events.
    for (int i = 0; i < 10; i++) @(posedge clkb);
    #1;
    base = sigb_cnt;
    start_seq();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
    drain("e2e");
    for (int i = 0; i < 10; i++) @(posedge clkb);
    #1;
    chk("e2e.pulse_out_count", pulse_cnt, 10);
    chk("e2e.signal_b_count", sigb_cnt - base, 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
